// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and frame timing.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // 8N1 frame plus the transmitter's trigger and done handshake overhead
  localparam int UART_FRAME_CYCLES = 12;
  localparam int DEFAULT_TIMEOUT   = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after i_ptr, wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_valid,
  output logic [IDW-1:0] o_index
);

  int pos;

  // Scan farthest-first so the nearest candidate after i_ptr is the last write
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    pos     = 0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(i_ptr) + k;
      if (pos >= N) pos = pos - N;
      if (i_req[pos[IDW-1:0]]) begin
        o_valid = 1'b1;
        o_index = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter among N requesters, with packet lock and done watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_byte,
  output logic           tx_send,
  input  logic           tx_done,
  output logic           busy,
  output logic [IDW-1:0] grant_id,
  output logic           timeout_err
);

  localparam int             WDW       = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  state_e         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant_id;
  logic           r_lock;
  logic           r_last;
  logic [WDW-1:0] r_wdog;
  logic [7:0]     r_tx_byte;

  logic           w_pick_vld;
  logic [IDW-1:0] w_pick_idx;
  logic [IDW-1:0] w_sel_idx;
  logic [N-1:0]   w_ready;
  logic           w_accept;
  logic           w_owner_vld;
  logic           w_done;
  logic           w_wdog_exp;

  rr_pick #(.N(N)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_vld),
    .o_index (w_pick_idx)
  );

  assign w_owner_vld = req_valid[r_grant_id];
  assign w_done      = (r_state == ST_WAIT) && tx_done;
  assign w_wdog_exp  = (r_state == ST_WAIT) && (r_wdog == WDOG_LAST);

  // Accept strobe: arbitration in IDLE, owner-only while a packet holds the lock
  always_comb begin
    w_ready   = '0;
    w_sel_idx = r_grant_id;
    if (!rst) begin
      if (r_state == ST_IDLE && w_pick_vld) begin
        w_ready[w_pick_idx] = 1'b1;
        w_sel_idx           = w_pick_idx;
      end else if (r_state == ST_HOLD && r_lock && w_owner_vld) begin
        w_ready[r_grant_id] = 1'b1;
      end
    end
  end

  assign w_accept = |w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= IDW'(N - 1);
      r_grant_id <= '0;
      r_lock     <= 1'b0;
      r_last     <= 1'b0;
      r_wdog     <= '0;
      r_tx_byte  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_tx_byte  <= req_data[w_sel_idx*8 +: 8];
            r_last     <= req_last[w_sel_idx];
            r_grant_id <= w_sel_idx;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wdog <= r_wdog + WDW'(1);
          // A done pulse on the final watchdog cycle still counts as completion
          if (w_done) begin
            if (r_last) begin
              r_rr_ptr <= r_grant_id;
              r_lock   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_lock  <= 1'b1;
              r_state <= ST_HOLD;
            end
          end else if (w_wdog_exp) begin
            r_rr_ptr <= r_grant_id;
            r_lock   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign tx_byte     = r_tx_byte;
  assign tx_send     = (r_state == ST_SEND);
  assign busy        = (r_state != ST_IDLE);
  assign grant_id    = r_grant_id;
  assign timeout_err = w_wdog_exp && !tx_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 32;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_send;
  logic           tx_done;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_byte     (tx_byte),
    .tx_send     (tx_send),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  typedef struct packed { logic [7:0] d; logic l; } ent_t;
  ent_t rq[N][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  int send_byte[$], send_grant[$], send_cyc[$], acc_idx[$], acc_cyc[$], tmo_cyc[$];
  int eq[$];

  bit gate = 0, x_mute = 0, x_rand = 0, stray = 0, x_armed = 0;
  int x_k = 0, x_delay = UART_FRAME_CYCLES;

  // Reference model: transaction view of the arbiter
  bit         m_send, m_fly, m_lock, m_last;
  int         m_age, m_own, m_ptr;
  logic [7:0] m_byte;

  function automatic void m_reset();
    m_send = 0; m_fly = 0; m_lock = 0; m_last = 0;
    m_age = 0; m_own = 0; m_ptr = N - 1; m_byte = 8'h00;
  endfunction

  function automatic int rr_first(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void cmp_q(string nm, int a[$], int e[$]);
    chk({nm, "_len"}, a.size(), e.size());
    for (int i = 0; i < a.size() && i < e.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), a[i], e[i]);
  endfunction

  function automatic void clear_logs();
    send_byte.delete(); send_grant.delete(); send_cyc.delete();
    acc_idx.delete(); acc_cyc.delete(); tmo_cyc.delete();
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int w;
    bit exp_tmo;
    cyc++;
    if (chk_en) begin
      exp_rdy = '0;
      w = -1;
      if (!rst && !m_send && !m_fly) begin
        if (m_lock) begin
          if (req_valid[m_own]) w = m_own;
        end else begin
          w = rr_first(req_valid, m_ptr);
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_tmo = m_fly && (m_age == TMO) && !tx_done;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("tx_send", 32'(tx_send), 32'(m_send));
      chk("tx_byte", 32'(tx_byte), 32'(m_byte));
      chk("grant_id", 32'(grant_id), m_own);
      chk("busy", 32'(busy), 32'(m_send || m_fly || m_lock));
      chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));
      if (tx_send === 1'b1) begin
        send_byte.push_back(int'(tx_byte));
        send_grant.push_back(int'(grant_id));
        send_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i] === 1'b1) begin acc_idx.push_back(i); acc_cyc.push_back(cyc); end
      if (timeout_err === 1'b1) tmo_cyc.push_back(cyc);
      if (rst) m_reset();
      else if (m_send) begin
        m_send = 0; m_fly = 1; m_age = 1;
      end else if (m_fly) begin
        if (tx_done) begin
          m_fly = 0; m_lock = !m_last;
          if (m_last) m_ptr = m_own;
        end else if (m_age == TMO) begin
          m_fly = 0; m_lock = 0; m_ptr = m_own;
        end else m_age++;
      end else if (w >= 0) begin
        m_own = w; m_byte = req_data[8*w +: 8]; m_last = req_last[w]; m_send = 1;
      end
    end
  end

  task automatic tick();
    logic [N-1:0] acc;
    bit tmo_prev;
    @(negedge clk);
    acc = req_valid & req_ready & {N{!rst}};
    tmo_prev = timeout_err;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
    tx_done = 1'b0;
    if (x_armed) begin
      x_k++;
      if (x_k == x_delay) begin tx_done = 1'b1; x_armed = 0; end
    end
    if (stray && tmo_prev) tx_done = 1'b1;
    if (tx_send) begin
      x_armed = !x_mute; x_k = 0;
      if (x_rand) x_delay = $urandom_range(12, 40);
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && (!gate || $urandom_range(3) != 0)) begin
        req_valid[i] = 1'b1; req_data[8*i +: 8] = rq[i][0].d; req_last[i] = rq[i][0].l;
      end else begin
        req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'($urandom); req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic wait_idle(int maxc);
    for (int k = 0; k < maxc && (pending() != 0 || busy || x_armed); k++) tick();
    tick();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pending", pending(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk_en = 1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_send", 32'(tx_send), 32'd0);

    // Single byte from requester 2
    clear_logs();
    rq[2].push_back('{8'h41, 1'b1});
    wait_idle(200);
    eq = {8'h41}; cmp_q("s1_byte", send_byte, eq);
    eq = {2};     cmp_q("s1_grant", send_grant, eq);
    eq = {2};     cmp_q("s1_acc", acc_idx, eq);
    if (send_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("s1_latency", send_cyc[0] - acc_cyc[0], 1);

    // Round robin, all four valid
    do_reset(); clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back('{8'(8'h10 + i), 1'b1});
    wait_idle(400);
    eq = {8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13}; cmp_q("rr_byte", send_byte, eq);
    eq = {0, 1, 2, 3, 0, 1, 2, 3}; cmp_q("rr_grant", send_grant, eq);

    // Packet lock: requester 1 holds the transmitter against requester 0
    do_reset(); clear_logs();
    rq[1].push_back('{8'hA0, 1'b0}); rq[1].push_back('{8'hA1, 1'b0}); rq[1].push_back('{8'hA2, 1'b1});
    tick();
    rq[0].push_back('{8'h55, 1'b1});
    wait_idle(400);
    eq = {8'hA0, 8'hA1, 8'hA2, 8'h55}; cmp_q("lock_byte", send_byte, eq);
    eq = {1, 1, 1, 0}; cmp_q("lock_acc", acc_idx, eq);

    // Timeout with a silent transmitter and a stray late done
    do_reset(); clear_logs();
    x_mute = 1; stray = 1;
    rq[0].push_back('{8'h77, 1'b1}); rq[1].push_back('{8'h88, 1'b1});
    wait_idle(400);
    x_mute = 0; stray = 0;
    chk("tmo_count", tmo_cyc.size(), 2);
    if (tmo_cyc.size() == 2 && send_cyc.size() == 2) begin
      chk("tmo_delay0", tmo_cyc[0] - send_cyc[0], 32);
      chk("tmo_delay1", tmo_cyc[1] - send_cyc[1], 32);
    end
    eq = {0, 1}; cmp_q("tmo_grant", send_grant, eq);

    // Reset while waiting on the second byte of a locked packet
    do_reset(); clear_logs();
    rq[2].push_back('{8'hB0, 1'b0}); rq[2].push_back('{8'hB1, 1'b1});
    for (int k = 0; k < 300 && send_byte.size() < 2; k++) tick();
    chk("mf_reach", send_byte.size(), 2);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("mf_busy", 32'(busy), 32'd0);
    chk("mf_grant", 32'(grant_id), 32'd0);
    chk("mf_byte", 32'(tx_byte), 32'd0);
    chk("mf_send", 32'(tx_send), 32'd0);
    repeat (15) tick();
    rq[3].push_back('{8'hC3, 1'b1}); rq[0].push_back('{8'hC0, 1'b1});
    wait_idle(400);
    eq = {8'hB0, 8'hB1, 8'hC0, 8'hC3}; cmp_q("mf_byte_seq", send_byte, eq);
    eq = {2, 2, 0, 3}; cmp_q("mf_grant_seq", send_grant, eq);

    // Done arrives on the last watchdog cycle
    do_reset(); clear_logs();
    x_delay = TMO;
    rq[1].push_back('{8'h5A, 1'b1}); rq[2].push_back('{8'h5B, 1'b1});
    wait_idle(400);
    x_delay = UART_FRAME_CYCLES;
    chk("edge_tmo", tmo_cyc.size(), 0);
    eq = {8'h5A, 8'h5B}; cmp_q("edge_byte", send_byte, eq);

    // Randomized packets, gaps and transmitter delays
    do_reset(); clear_logs();
    gate = 1; x_rand = 1;
    begin
      int nbytes = 0;
      for (int p = 0; p < 60; p++) begin
        int r = $urandom_range(N - 1);
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) rq[r].push_back('{8'($urandom), 1'(b == len - 1)});
        nbytes += len;
        repeat ($urandom_range(0, 20)) tick();
      end
      wait_idle(20000);
      chk("rand_count", send_byte.size(), nbytes);
    end
    gate = 0; x_rand = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule
